fetch_decode_stage: RTL and testbench

Instruction-fetch and decode front end of the single-cycle LEGv8 CPU. It holds the 64-bit program counter and computes the next PC from three sources: sequential PC+4, an external branch target, or a register value for BR. It reads a 32-bit instruction from an internal ROM and decodes it into register addresses, immediates and datapath control signals for the execute and memory stages.

---
 rtl/fetch_decode_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end of the single-cycle LEGv8 CPU: program counter, next-PC select,
// instruction ROM and opcode decode into register fields, immediates and control lines.
module fetch_decode_stage #(
  parameter int          IMEM_WORDS = 1024,
  parameter string       PROGRAM    = "program.txt",
  // ROM contents as generated from the PROGRAM hex image; words not listed read as 0
  parameter logic [31:0] ROM_IMAGE [IMEM_WORDS] = '{default: 32'h0}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        negative,
  input  logic        zero,
  input  logic        BrTaken,
  input  logic [63:0] Da,
  input  logic [63:0] new_pc2,
  output logic [63:0] pc,
  output logic [63:0] BLT,
  output logic [18:0] COND_BR_addr,
  output logic [25:0] BR_addr,
  output logic [4:0]  Rd,
  output logic [4:0]  Rn,
  output logic [4:0]  Rm,
  output logic [11:0] ALU_imm,
  output logic [8:0]  DT_addr,
  output logic [5:0]  shamt,
  output logic [2:0]  ALUop,
  output logic [3:0]  xfer_size,
  output logic        Reg2Loc,
  output logic        ALUsrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        BLsignal,
  output logic        cbz,
  output logic        branch,
  output logic        cond,
  output logic        update,
  output logic        UnCondBr,
  output logic        DTsignal
);

  localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam string unused_program = PROGRAM;

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b110;

  logic [63:0]      pc_q, pc_d;
  logic [63:0]      pc_plus4;
  logic [31:0]      instr;
  logic [IDX_W-1:0] rom_idx;
  logic             in_range;

  logic is_addi, is_adds, is_subs, is_and, is_eor, is_lsr;
  logic is_ldur, is_ldurb, is_stur, is_sturb;
  logic is_b, is_bl, is_bcond, is_cbz, is_br;

  // Flags are consumed by the external branch unit; the PC byte offset is ignored by the ROM
  logic unused_bits;
  assign unused_bits = negative ^ zero ^ pc_q[1] ^ pc_q[0];

  // Instruction ROM, asynchronous read
  assign in_range = (pc_q[63:2] < 62'(IMEM_WORDS));
  assign rom_idx  = pc_q[IDX_W+1:2];
  assign instr    = in_range ? ROM_IMAGE[rom_idx] : 32'h0;

  assign is_addi  = (instr[31:22] == 10'b1001000100);
  assign is_adds  = (instr[31:21] == 11'b10101011000);
  assign is_subs  = (instr[31:21] == 11'b11101011000);
  assign is_and   = (instr[31:21] == 11'b10001010000);
  assign is_eor   = (instr[31:21] == 11'b11001010000);
  assign is_lsr   = (instr[31:21] == 11'b11010011010);
  assign is_ldur  = (instr[31:21] == 11'b11111000010);
  assign is_ldurb = (instr[31:21] == 11'b00111000010);
  assign is_stur  = (instr[31:21] == 11'b11111000000);
  assign is_sturb = (instr[31:21] == 11'b00111000000);
  assign is_br    = (instr[31:21] == 11'b11010110000);
  assign is_b     = (instr[31:26] == 6'b000101);
  assign is_bl    = (instr[31:26] == 6'b100101);
  assign is_bcond = (instr[31:24] == 8'b01010100);
  assign is_cbz   = (instr[31:24] == 8'b10110100);

  // State register: reset clears the PC immediately, independent of the clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 64'h0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Next-PC select: a BR in the current word overrides the external branch request
  assign pc_plus4 = pc_q + 64'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (is_br) begin
      pc_d = Da;
    end else if (BrTaken) begin
      pc_d = new_pc2;
    end
  end

  // Control decode
  always_comb begin
    Reg2Loc  = 1'b0;
    ALUsrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    BLsignal = 1'b0;
    cbz      = 1'b0;
    branch   = 1'b0;
    cond     = 1'b0;
    update   = 1'b0;
    UnCondBr = 1'b0;
    DTsignal = 1'b0;
    ALUop    = OP_PASSB;
    if (is_addi) begin
      RegWrite = 1'b1;
      ALUsrc   = 1'b1;
      ALUop    = OP_ADD;
    end else if (is_adds || is_subs) begin
      RegWrite = 1'b1;
      Reg2Loc  = 1'b1;
      update   = 1'b1;
      ALUop    = is_subs ? OP_SUB : OP_ADD;
    end else if (is_and || is_eor) begin
      RegWrite = 1'b1;
      Reg2Loc  = 1'b1;
      ALUop    = is_eor ? OP_XOR : OP_AND;
    end else if (is_lsr) begin
      RegWrite = 1'b1;
    end else if (is_ldur || is_ldurb) begin
      RegWrite = 1'b1;
      ALUsrc   = 1'b1;
      DTsignal = 1'b1;
      MemtoReg = 1'b1;
      ALUop    = OP_ADD;
    end else if (is_stur || is_sturb) begin
      MemWrite = 1'b1;
      ALUsrc   = 1'b1;
      DTsignal = 1'b1;
      ALUop    = OP_ADD;
    end else if (is_b) begin
      UnCondBr = 1'b1;
    end else if (is_bl) begin
      UnCondBr = 1'b1;
      RegWrite = 1'b1;
      BLsignal = 1'b1;
    end else if (is_bcond) begin
      branch   = 1'b1;
      cond     = 1'b1;
    end else if (is_cbz) begin
      branch   = 1'b1;
      cbz      = 1'b1;
    end
  end

  assign pc           = pc_q;
  assign BLT          = pc_plus4;
  assign COND_BR_addr = instr[23:5];
  assign BR_addr      = instr[25:0];
  // BL links into X30 regardless of the Rd field
  assign Rd           = is_bl ? 5'd30 : instr[4:0];
  assign Rn           = instr[9:5];
  assign Rm           = instr[20:16];
  assign ALU_imm      = instr[21:10];
  assign DT_addr      = instr[20:12];
  assign shamt        = instr[15:10];
  assign xfer_size    = (is_ldurb || is_sturb) ? 4'd1 : 4'd8;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed rows push expected state, a negedge
// monitor pops and compares against the DUT outputs.
module tb_fetch_decode_stage;

  localparam logic [31:0] W_ADDI  = 32'h9101F96F; // ADDI X15, X11, #126
  localparam logic [31:0] W_UNK   = 32'hFFFFFFFF;
  localparam logic [31:0] W_BL    = 32'h94000003;
  localparam logic [31:0] W_STURB = 32'h38005041; // STURB X1, [X2, #5]
  localparam logic [31:0] W_SUBS  = 32'hEB050083; // SUBS X3, X4, X5
  localparam logic [31:0] W_LDUR  = 32'hF8400107; // LDUR X7, [X8, #0]
  localparam logic [31:0] W_CBZ   = 32'hB4000049; // CBZ X9, #2
  localparam logic [31:0] W_BCOND = 32'h54000080; // B.EQ #4
  localparam logic [31:0] W_EOR   = 32'hCA0C016A; // EOR X10, X11, X12
  localparam logic [31:0] W_BR    = 32'hD61F03C0; // BR X30

  localparam logic [31:0] IMAGE [1024] = '{
    0: W_ADDI, 16: W_UNK, 17: W_BL, 18: W_STURB, 19: W_SUBS, 20: W_LDUR,
    21: W_CBZ, 22: W_BCOND, 23: W_EOR, 24: W_BR, default: 32'h0};

  localparam int I_NOP = 0, I_ADDI = 1, I_UNK = 2, I_BL = 3, I_STURB = 4, I_SUBS = 5;
  localparam int I_LDUR = 6, I_CBZ = 7, I_BCOND = 8, I_EOR = 9, I_BR = 10;

  logic        clk, reset, negative, zero, BrTaken;
  logic [63:0] Da, new_pc2, pc, BLT;
  logic [18:0] COND_BR_addr;
  logic [25:0] BR_addr;
  logic [4:0]  Rd, Rn, Rm;
  logic [11:0] ALU_imm;
  logic [8:0]  DT_addr;
  logic [5:0]  shamt;
  logic [2:0]  ALUop;
  logic [3:0]  xfer_size;
  logic Reg2Loc, ALUsrc, MemtoReg, RegWrite, MemWrite, BLsignal;
  logic cbz, branch, cond, update, UnCondBr, DTsignal;

  fetch_decode_stage #(
    .IMEM_WORDS(1024),
    .PROGRAM("program.txt"),
    .ROM_IMAGE(IMAGE)
  ) dut (
    .clk(clk), .reset(reset), .negative(negative), .zero(zero), .BrTaken(BrTaken),
    .Da(Da), .new_pc2(new_pc2), .pc(pc), .BLT(BLT), .COND_BR_addr(COND_BR_addr),
    .BR_addr(BR_addr), .Rd(Rd), .Rn(Rn), .Rm(Rm), .ALU_imm(ALU_imm), .DT_addr(DT_addr),
    .shamt(shamt), .ALUop(ALUop), .xfer_size(xfer_size), .Reg2Loc(Reg2Loc),
    .ALUsrc(ALUsrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .BLsignal(BLsignal), .cbz(cbz), .branch(branch), .cond(cond), .update(update),
    .UnCondBr(UnCondBr), .DTsignal(DTsignal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
    logic [4:0]  rd, rn, rm;
    logic [11:0] imm;
    logic [11:0] ctrl; // {Reg2Loc,ALUsrc,MemtoReg,RegWrite,MemWrite,BLsignal,cbz,branch,cond,update,UnCondBr,DTsignal}
    logic [2:0]  aluop;
    logic [3:0]  xfer;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        br;
    logic [63:0] np;
    logic [63:0] da;
    logic [63:0] pc;
    logic [3:0]  id;
  } row_t;

  localparam int NROWS = 23;
  row_t rows [NROWS] = '{
    '{1'b1, 1'b0, 64'd0,   64'd0, 64'd0,  4'(I_ADDI)},
    '{1'b1, 1'b1, 64'd64,  64'd0, 64'd0,  4'(I_ADDI)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd0,  4'(I_ADDI)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd4,  4'(I_NOP)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd8,  4'(I_NOP)},
    '{1'b0, 1'b1, 64'd64,  64'd0, 64'd12, 4'(I_NOP)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd64, 4'(I_UNK)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd68, 4'(I_BL)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd72, 4'(I_STURB)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd76, 4'(I_SUBS)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd80, 4'(I_LDUR)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd84, 4'(I_CBZ)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd88, 4'(I_BCOND)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd92, 4'(I_EOR)},
    '{1'b0, 1'b1, 64'd200, 64'd1, 64'd96, 4'(I_BR)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd1,  4'(I_ADDI)},
    '{1'b0, 1'b1, 64'd64,  64'd0, 64'd5,  4'(I_NOP)},
    '{1'b0, 1'b1, 64'd64,  64'd0, 64'd64, 4'(I_UNK)},
    '{1'b1, 1'b0, 64'd0,   64'd0, 64'd0,  4'(I_ADDI)},
    '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 4'(I_ADDI)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 4'(I_NOP)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd0,  4'(I_ADDI)},
    '{1'b0, 1'b0, 64'd0,   64'd0, 64'd4,  4'(I_NOP)}
  };

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_tx     = 0;
  logic stim_done = 1'b0;

  function automatic exp_t exp_of(input int id, input logic [63:0] p);
    exp_t e;
    e = '0;
    e.pc   = p;
    e.xfer = 4'd8;
    case (id)
      I_ADDI:  begin e.word = W_ADDI;  e.rd = 5'd15; e.rn = 5'd11; e.rm = 5'd1;  e.imm = 12'd126;
                     e.ctrl = 12'b0101_0000_0000; e.aluop = 3'b010; end
      I_UNK:   begin e.word = W_UNK;   e.rd = 5'd31; e.rn = 5'd31; e.rm = 5'd31; e.imm = 12'd4095; end
      I_BL:    begin e.word = W_BL;    e.rd = 5'd30; e.ctrl = 12'b0001_0100_0010; end
      I_STURB: begin e.word = W_STURB; e.rd = 5'd1;  e.rn = 5'd2;  e.imm = 12'd20;
                     e.ctrl = 12'b0100_1000_0001; e.aluop = 3'b010; e.xfer = 4'd1; end
      I_SUBS:  begin e.word = W_SUBS;  e.rd = 5'd3;  e.rn = 5'd4;  e.rm = 5'd5;  e.imm = 12'd320;
                     e.ctrl = 12'b1001_0000_0100; e.aluop = 3'b011; end
      I_LDUR:  begin e.word = W_LDUR;  e.rd = 5'd7;  e.rn = 5'd8;
                     e.ctrl = 12'b0111_0000_0001; e.aluop = 3'b010; end
      I_CBZ:   begin e.word = W_CBZ;   e.rd = 5'd9;  e.rn = 5'd2;  e.ctrl = 12'b0000_0011_0000; end
      I_BCOND: begin e.word = W_BCOND; e.rn = 5'd4;  e.ctrl = 12'b0000_0001_1000; end
      I_EOR:   begin e.word = W_EOR;   e.rd = 5'd10; e.rn = 5'd11; e.rm = 5'd12; e.imm = 12'd768;
                     e.ctrl = 12'b1001_0000_0000; e.aluop = 3'b110; end
      I_BR:    begin e.word = W_BR;    e.rn = 5'd30; e.rm = 5'd31; e.imm = 12'd1984; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Stimulus: drive one row just after each rising edge and queue the expected state
  initial begin
    reset = 1'b1; negative = 1'b0; zero = 1'b0; BrTaken = 1'b0; Da = '0; new_pc2 = '0;
    for (int i = 0; i < NROWS; i++) begin
      @(posedge clk); #1;
      reset   = rows[i].rst;
      BrTaken = rows[i].br;
      new_pc2 = rows[i].np;
      Da      = rows[i].da;
      negative = i[0];
      zero     = i[1];
      sb_q.push_back(exp_of(int'(rows[i].id), rows[i].pc));
    end
    @(posedge clk); #1;
    stim_done = 1'b1;
  end

  // Monitor: compare on the falling edge whenever an expectation is pending
  initial begin
    exp_t e;
    int   f0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e  = sb_q.pop_front();
        f0 = n_fail;
        chk("pc",        pc,             e.pc);
        chk("BLT",       BLT,            e.pc + 64'd4);
        chk("Rd",        64'(Rd),        64'(e.rd));
        chk("Rn",        64'(Rn),        64'(e.rn));
        chk("Rm",        64'(Rm),        64'(e.rm));
        chk("ALU_imm",   64'(ALU_imm),   64'(e.imm));
        chk("BR_addr",   64'(BR_addr),   64'(e.word[25:0]));
        chk("COND_addr", 64'(COND_BR_addr), 64'(e.word[23:5]));
        chk("DT_addr",   64'(DT_addr),   64'(e.word[20:12]));
        chk("shamt",     64'(shamt),     64'(e.word[15:10]));
        chk("ctrl", 64'({Reg2Loc, ALUsrc, MemtoReg, RegWrite, MemWrite, BLsignal,
                          cbz, branch, cond, update, UnCondBr, DTsignal}), 64'(e.ctrl));
        chk("ALUop",     64'(ALUop),     64'(e.aluop));
        chk("xfer_size", 64'(xfer_size), 64'(e.xfer));
        $display("tx %0d pc=%h rd=%0d aluop=%b errors=%0d", n_tx, pc, Rd, ALUop, n_fail - f0);
        n_tx++;
      end
    end
  end

  // End of run: bounded wait for stimulus, then drain checks and the summary
  initial begin
    fork
      wait (stim_done);
      repeat (NROWS * 4 + 50) @(posedge clk);
    join_any
    disable fork;
    @(negedge clk); #1;
    chk("stim_done",  64'(stim_done),   64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("tx_count",   64'(n_tx),        64'(NROWS));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
